// File: rtl/exc_flush_ctrl.sv
// rtl/exc_flush_ctrl.sv - exception/ERET pipeline flush and PC redirect sequencer
// Build option: FLUSH_WAIT_INST_EN drains inst requests too, removing stale-response discard.
module exc_flush_ctrl #(
    parameter logic [31:0] EXC_VECTOR      = 32'hBFC00380,
    parameter int          MAX_OUTSTANDING = 2,
    parameter int          CNT_W           = 2
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        exc_req,
    input  logic        eret_req,
    input  logic [31:0] epc,
    input  logic        inst_req_fire,
    input  logic        inst_resp,
    input  logic        data_req_fire,
    input  logic        data_resp,
    input  logic        redirect_ready,
    output logic        stall_all,
    output logic        flush,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc,
    output logic        inst_req_block,
    output logic        discard_inst_resp,
    output logic        busy,
    output logic        proto_err
);

    localparam logic [1:0] S_IDLE     = 2'd0;
    localparam logic [1:0] S_DRAIN    = 2'd1;
    localparam logic [1:0] S_FLUSH    = 2'd2;
    localparam logic [1:0] S_REDIRECT = 2'd3;

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUTSTANDING);

    logic [1:0]       state, state_nxt;
    logic [CNT_W-1:0] inst_cnt, inst_nxt, data_cnt, data_nxt;
    logic             inst_err, data_err;
    logic [31:0]      target;
    logic             drain_done;
    logic             req_any;

    // Returns {error, next_count}; an illegal step holds the count.
    function automatic logic [CNT_W:0] cnt_step(input logic [CNT_W-1:0] c,
                                                 input logic up, input logic dn);
        logic [CNT_W:0] r;
        r = {1'b0, c};
        if (up && !dn) begin
            if (c == MAX_CNT) r = {1'b1, c};
            else              r = {1'b0, c + 1'b1};
        end else if (dn && !up) begin
            if (c == '0) r = {1'b1, c};
            else         r = {1'b0, c - 1'b1};
        end
        return r;
    endfunction

    always_comb begin
        {inst_err, inst_nxt} = cnt_step(inst_cnt, inst_req_fire, inst_resp);
        {data_err, data_nxt} = cnt_step(data_cnt, data_req_fire, data_resp);
    end

`ifdef FLUSH_WAIT_INST_EN
    assign drain_done = (data_nxt == '0) && (inst_nxt == '0);
`else
    assign drain_done = (data_nxt == '0);
`endif

    assign req_any = exc_req || eret_req;

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:     if (req_any) state_nxt = drain_done ? S_FLUSH : S_DRAIN;
            S_DRAIN:    if (drain_done) state_nxt = S_FLUSH;
            S_FLUSH:    state_nxt = S_REDIRECT;
            S_REDIRECT: if (redirect_ready) state_nxt = S_IDLE;
            default:    state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state     <= S_IDLE;
            inst_cnt  <= '0;
            data_cnt  <= '0;
            target    <= '0;
            proto_err <= 1'b0;
        end else begin
            state    <= state_nxt;
            inst_cnt <= inst_nxt;
            data_cnt <= data_nxt;
            if (inst_err || data_err) proto_err <= 1'b1;
            if (state == S_IDLE) begin
                if (exc_req)       target <= EXC_VECTOR;
                else if (eret_req) target <= epc;
            end
        end
    end

`ifdef FLUSH_WAIT_INST_EN
    assign discard_inst_resp = 1'b0;
`else
    logic [CNT_W-1:0] discard_cnt;

    assign discard_inst_resp = inst_resp && (discard_cnt != '0);

    // Everything still outstanding at the flush predates the redirect; responses are in order.
    always_ff @(posedge clk) begin
        if (!resetn)                discard_cnt <= '0;
        else if (state == S_FLUSH)  discard_cnt <= inst_nxt;
        else if (discard_inst_resp) discard_cnt <= discard_cnt - 1'b1;
    end
`endif

    assign busy           = (state != S_IDLE);
    assign flush          = (state == S_FLUSH);
    assign redirect_valid = (state == S_REDIRECT);
    assign redirect_pc    = redirect_valid ? target : 32'h0;
    assign stall_all      = ((state == S_IDLE) && req_any) || (state == S_DRAIN) || flush;
    assign inst_req_block = (inst_cnt == MAX_CNT) || (state == S_DRAIN) || flush;

endmodule

// File: tb/tb_exc_flush_ctrl.sv
// tb/tb_exc_flush_ctrl.sv - table-driven directed bench for exc_flush_ctrl
module tb_exc_flush_ctrl;

    localparam logic [31:0] VEC = 32'hBFC00380;
    localparam logic [31:0] EPC = 32'h80001234;

    logic        clk = 1'b0;
    logic        resetn;
    logic        exc_req, eret_req;
    logic [31:0] epc;
    logic        inst_req_fire, inst_resp, data_req_fire, data_resp, redirect_ready;
    logic        stall_all, flush, redirect_valid;
    logic [31:0] redirect_pc;
    logic        inst_req_block, discard_inst_resp, busy, proto_err;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    exc_flush_ctrl dut (
        .clk(clk), .resetn(resetn), .exc_req(exc_req), .eret_req(eret_req), .epc(epc),
        .inst_req_fire(inst_req_fire), .inst_resp(inst_resp),
        .data_req_fire(data_req_fire), .data_resp(data_resp),
        .redirect_ready(redirect_ready), .stall_all(stall_all), .flush(flush),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .inst_req_block(inst_req_block), .discard_inst_resp(discard_inst_resp),
        .busy(busy), .proto_err(proto_err)
    );

    typedef struct {
        logic        rstn, exc, eret, ifire, iresp, dfire, dresp, rdy;
        logic [31:0] epc;
        logic [6:0]  flags;   // {stall, flush, rvalid, block, discard, busy, perr}
        logic [31:0] rpc;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic rstn, exc, eret, ifire, iresp, dfire, dresp, rdy,
                                input logic [6:0] flags, input logic [31:0] rpc);
        vec_t v;
        v.rstn = rstn; v.exc = exc; v.eret = eret; v.ifire = ifire; v.iresp = iresp;
        v.dfire = dfire; v.dresp = dresp; v.rdy = rdy; v.epc = EPC;
        v.flags = flags; v.rpc = rpc;
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic rstn, exc, eret, ifire, iresp, dfire, dresp, rdy);
        resetn = rstn; exc_req = exc; eret_req = eret; epc = EPC;
        inst_req_fire = ifire; inst_resp = iresp;
        data_req_fire = dfire; data_resp = dresp; redirect_ready = rdy;
    endtask

    function automatic logic [6:0] flags_now();
        return {stall_all, flush, redirect_valid, inst_req_block, discard_inst_resp, busy, proto_err};
    endfunction

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    int flush_seen, drain_cycles;
    logic redirect_seen;
    logic [31:0] seen_pc;

    initial begin
        //                rst exc ere ifr irs dfr drs rdy   flags S F R B D Y P   rpc
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 7'b0000000, 0));    // reset state
        vecs.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0, 7'b1000000, 0));    // idle exception
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 7'b1101010, 0));    // flush at +1
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 7'b0010010, VEC));  // redirect at +2, held
        vecs.push_back(mk(1, 1, 0, 0, 0, 0, 0, 1, 7'b0010010, VEC));  // exc ignored while busy
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 7'b0000000, 0));    // back to idle
        vecs.push_back(mk(1, 0, 1, 0, 0, 0, 0, 0, 7'b1000000, 0));    // eret
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 7'b1101010, 0));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 1, 7'b0010010, EPC));
        vecs.push_back(mk(1, 1, 1, 0, 0, 0, 0, 0, 7'b1000000, 0));    // exc beats eret
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 7'b1101010, 0));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 1, 7'b0010010, VEC));
        vecs.push_back(mk(1, 0, 0, 0, 0, 1, 0, 0, 7'b0000000, 0));    // data req outstanding
        vecs.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0, 7'b1000000, 0));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 7'b1001010, 0));    // drain 1
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 7'b1001010, 0));    // drain 2
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 1, 0, 7'b1001010, 0));    // drain 3, resp
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 7'b1101010, 0));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 1, 7'b0010010, VEC));
        vecs.push_back(mk(1, 0, 0, 1, 0, 0, 0, 0, 7'b0000000, 0));    // two fetches out
        vecs.push_back(mk(1, 0, 0, 1, 0, 0, 0, 0, 7'b0000000, 0));
        vecs.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0, 7'b1001000, 0));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 7'b1101010, 0));
        vecs.push_back(mk(1, 0, 0, 0, 1, 0, 0, 1, 7'b0011110, VEC));  // stale resp 1
        vecs.push_back(mk(1, 0, 0, 1, 1, 0, 0, 0, 7'b0000100, 0));    // stale resp 2 + new req
        vecs.push_back(mk(1, 0, 0, 0, 1, 0, 0, 0, 7'b0000000, 0));    // post-redirect resp kept
        vecs.push_back(mk(1, 0, 0, 1, 0, 0, 0, 0, 7'b0000000, 0));    // cnt 1
        vecs.push_back(mk(1, 0, 0, 1, 1, 0, 0, 0, 7'b0000000, 0));    // fire+resp: still 1
        vecs.push_back(mk(1, 0, 0, 1, 0, 0, 0, 0, 7'b0000000, 0));    // cnt 2
        vecs.push_back(mk(1, 0, 0, 1, 0, 0, 0, 0, 7'b0001000, 0));    // overflow
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 7'b0001001, 0));
        vecs.push_back(mk(1, 0, 0, 0, 1, 0, 0, 0, 7'b0001001, 0));    // held at 2
        vecs.push_back(mk(1, 0, 0, 0, 1, 0, 0, 0, 7'b0000001, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 7'b0000001, 0));    // reset clears err
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 7'b0000000, 0));
        vecs.push_back(mk(1, 0, 0, 0, 1, 0, 0, 0, 7'b0000000, 0));    // underflow
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 7'b0000001, 0));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 7'b0000001, 0));    // sticky
        vecs.push_back(mk(1, 0, 0, 0, 0, 1, 0, 0, 7'b0000001, 0));
        vecs.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0, 7'b1000001, 0));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 7'b1001011, 0));    // in drain
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 7'b1001011, 0));    // reset mid-drain
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 1, 7'b0000000, 0));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 1, 7'b0000000, 0));    // no late flush
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 1, 7'b0000000, 0));    // no late redirect

        drive(0, 0, 0, 0, 0, 0, 0, 0);
        next_cycle();

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].rstn, vecs[i].exc, vecs[i].eret, vecs[i].ifire, vecs[i].iresp,
                  vecs[i].dfire, vecs[i].dresp, vecs[i].rdy);
            @(negedge clk);
            check($sformatf("vec%0d flags", i), 64'(flags_now()), 64'(vecs[i].flags));
            check($sformatf("vec%0d redirect_pc", i), 64'(redirect_pc), 64'(vecs[i].rpc));
            next_cycle();
        end

        // Inst response in the FLUSH cycle itself must not be counted as stale twice.
        drive(1, 0, 0, 1, 0, 0, 0, 0); next_cycle();
        drive(1, 0, 0, 1, 0, 0, 0, 0); next_cycle();
        drive(1, 1, 0, 0, 0, 0, 0, 0); next_cycle();
        drive(1, 0, 0, 0, 1, 0, 0, 0);
        @(negedge clk);
        check("flushcyc flush", 64'(flush), 64'd1);
        check("flushcyc discard", 64'(discard_inst_resp), 64'd0);
        next_cycle();
        drive(1, 0, 0, 0, 1, 0, 0, 1);
        @(negedge clk);
        check("redir discard", 64'(discard_inst_resp), 64'd1);
        next_cycle();
        drive(1, 0, 0, 1, 0, 0, 0, 0); next_cycle();
        drive(1, 0, 0, 0, 1, 0, 0, 0);
        @(negedge clk);
        check("new resp kept", 64'(discard_inst_resp), 64'd0);
        check("no proto_err", 64'(proto_err), 64'd0);
        next_cycle();

        // Bounded drain: data resp two cycles into DRAIN, expect three drain cycles, one flush.
        drive(1, 0, 0, 0, 0, 1, 0, 0); next_cycle();
        drive(1, 1, 0, 0, 0, 0, 0, 0); next_cycle();
        flush_seen = 0; drain_cycles = 0; redirect_seen = 1'b0; seen_pc = '0;
        for (int c = 0; c < 20 && !redirect_seen; c++) begin
            drive(1, 0, 0, 0, 0, 0, (c == 2), 1);
            @(negedge clk);
            if (flush) flush_seen++;
            if (busy && stall_all && !flush) drain_cycles++;
            if (redirect_valid) begin
                redirect_seen = 1'b1;
                seen_pc = redirect_pc;
            end
            next_cycle();
        end
        check("drain redirect seen", 64'(redirect_seen), 64'd1);
        check("drain flush count", 64'(flush_seen), 64'd1);
        check("drain cycles", 64'(drain_cycles), 64'd3);
        check("drain redirect_pc", 64'(seen_pc), 64'(VEC));
        drive(1, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        check("drain end idle", 64'(busy), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
